// File: rtl/rom_program_sequencer_if.sv
// Issue channel between the program sequencer and the datapath.
// The master side presents a decoded operation; the slave side accepts it.
interface rom_program_sequencer_if;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [2:0] op_a;
    logic [1:0] op_b;

    modport master (
        output op_valid,
        output op_code,
        output op_a,
        output op_b,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_a,
        input  op_b,
        output op_ready
    );
endinterface

// File: rtl/rom_program_sequencer.sv
// Fetch/decode sequencer for the lab processor's program ROM. Jumps and halts are
// resolved here; execute-class opcodes go out to the datapath over a valid/ready channel.
module rom_program_sequencer #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STEP_LIMIT = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic [ADDR_W-1:0]               rom_addr,
    input  logic [DATA_W-1:0]               rom_data,
    input  logic                            zero_flag,
    rom_program_sequencer_if.master         op_if,
    output logic [ADDR_W-1:0]               pc,
    output logic                            busy,
    output logic                            halted,
    output logic                            err
);

    localparam int unsigned StepW = 8;

    localparam logic [2:0] OpJmp  = 3'b101;
    localparam logic [2:0] OpJz   = 3'b110;
    localparam logic [2:0] OpHalt = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StHalt
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [StepW-1:0]    step_cnt_q, step_cnt_d;
    logic [2:0]          op_code_q, op_code_d;
    logic [2:0]          op_a_q, op_a_d;
    logic [1:0]          op_b_q, op_b_d;
    logic                op_valid_q, op_valid_d;
    logic                err_q, err_d;

    logic [2:0]          ir_opcode;
    logic [ADDR_W-1:0]   ir_target;

    assign ir_opcode = ir_q[DATA_W-1 -: 3];
    assign ir_target = ir_q[ADDR_W-1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        step_cnt_d = step_cnt_q;
        op_code_d  = op_code_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d       = '0;
                    step_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = StFetch;
                end
            end

            StFetch: begin
                ir_d    = rom_data;
                state_d = StDecode;
            end

            StDecode: begin
                // Watchdog: the instruction in ir is dropped and pc stays on it.
                if (step_cnt_q == StepW'(STEP_LIMIT)) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    step_cnt_d = step_cnt_q + StepW'(1);
                    case (ir_opcode)
                        OpJmp: begin
                            // A jump to itself marks the end of the program.
                            if (ir_target == pc_q) begin
                                state_d = StHalt;
                            end else begin
                                pc_d    = ir_target;
                                state_d = StFetch;
                            end
                        end
                        OpJz: begin
                            pc_d    = zero_flag ? ir_target : pc_q + ADDR_W'(1);
                            state_d = StFetch;
                        end
                        OpHalt: begin
                            state_d = StHalt;
                        end
                        default: begin
                            op_code_d  = ir_opcode;
                            op_a_d     = ir_q[4:2];
                            op_b_d     = ir_q[1:0];
                            op_valid_d = 1'b1;
                            state_d    = StIssue;
                        end
                    endcase
                end
            end

            StIssue: begin
                if (op_valid_q && op_if.op_ready) begin
                    op_valid_d = 1'b0;
                    pc_d       = pc_q + ADDR_W'(1);
                    state_d    = StFetch;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            ir_q       <= '0;
            step_cnt_q <= '0;
            op_code_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            step_cnt_q <= step_cnt_d;
            op_code_q  <= op_code_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            err_q      <= err_d;
        end
    end

    assign rom_addr       = pc_q;
    assign pc             = pc_q;
    assign busy           = (state_q == StFetch) || (state_q == StDecode) ||
                            (state_q == StIssue);
    assign halted         = (state_q == StHalt);
    assign err            = err_q;

    assign op_if.op_valid = op_valid_q;
    assign op_if.op_code  = op_code_q;
    assign op_if.op_a     = op_a_q;
    assign op_if.op_b     = op_b_q;

endmodule

// File: tb/tb_rom_program_sequencer.sv
// Directed bench for rom_program_sequencer: shipped program, backpressure, JZ,
// async reset, PC wrap, plus a second instance with a short watchdog limit.
module tb_rom_program_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       zero_flag;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [4:0] pc;
    logic       busy;
    logic       halted;
    logic       err;
    logic [7:0] rom_mem [0:31];

    logic       wd_start;
    logic [4:0] wd_rom_addr;
    logic [7:0] wd_rom_data;
    logic       wd_zero_flag;
    logic [4:0] wd_pc;
    logic       wd_busy;
    logic       wd_halted;
    logic       wd_err;

    int n_checks;
    int n_errors;
    int n_iss;
    int busy_cnt;
    logic [7:0] iss_fld [0:299];
    logic [4:0] iss_pc  [0:299];

    rom_program_sequencer_if op_if ();
    rom_program_sequencer_if wd_if ();

    rom_program_sequencer #(.ADDR_W(5), .DATA_W(8), .STEP_LIMIT(255)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .zero_flag(zero_flag),
        .op_if    (op_if.master),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted),
        .err      (err)
    );

    rom_program_sequencer #(.ADDR_W(5), .DATA_W(8), .STEP_LIMIT(4)) dut_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (wd_start),
        .rom_addr (wd_rom_addr),
        .rom_data (wd_rom_data),
        .zero_flag(wd_zero_flag),
        .op_if    (wd_if.master),
        .pc       (wd_pc),
        .busy     (wd_busy),
        .halted   (wd_halted),
        .err      (wd_err)
    );

    assign rom_data       = rom_mem[rom_addr];
    assign wd_rom_data    = 8'h00;
    assign wd_zero_flag   = 1'b0;
    assign wd_if.op_ready = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input logic [7:0] val);
        for (int i = 0; i < 32; i++) rom_mem[i] = val;
    endtask

    task automatic load_shipped();
        fill_rom(8'hE0);
        rom_mem[0]  = 8'b010_100_00;
        rom_mem[1]  = 8'b000_111_10;
        rom_mem[2]  = 8'b101_01000;
        rom_mem[8]  = 8'b000_110_00;
        rom_mem[9]  = 8'b001_101_00;
        rom_mem[10] = 8'b101_01010;
    endtask

    // Leaves the bench on the negedge where the DUT has just entered FETCH.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_halt(input int max_cyc);
        int cyc;
        cyc      = 0;
        n_iss    = 0;
        busy_cnt = 0;
        while (!halted && cyc < max_cyc) begin
            if (busy) busy_cnt++;
            if (op_if.op_valid && op_if.op_ready && n_iss < 300) begin
                iss_fld[n_iss] = {op_if.op_code, op_if.op_a, op_if.op_b};
                iss_pc[n_iss]  = pc;
                n_iss++;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("halt_timeout", halted, 1'b1);
    endtask

    task automatic check_shipped();
        check_eq("ship_n_iss", n_iss, 4);
        check_eq("ship_fld0", iss_fld[0], {3'd2, 3'd4, 2'd0});
        check_eq("ship_pc0", iss_pc[0], 0);
        check_eq("ship_fld1", iss_fld[1], {3'd0, 3'd7, 2'd2});
        check_eq("ship_pc1", iss_pc[1], 1);
        check_eq("ship_fld2", iss_fld[2], {3'd0, 3'd6, 2'd0});
        check_eq("ship_pc2", iss_pc[2], 8);
        check_eq("ship_fld3", iss_fld[3], {3'd1, 3'd5, 2'd0});
        check_eq("ship_pc3", iss_pc[3], 9);
        check_eq("ship_err", err, 1'b0);
        check_eq("ship_pc_end", pc, 10);
        check_eq("ship_busy_cycles", busy_cnt, 16);
        check_eq("ship_hold_fields", {op_if.op_code, op_if.op_a, op_if.op_b},
                 {3'd1, 3'd5, 2'd0});
        check_eq("ship_valid_low", op_if.op_valid, 1'b0);
    endtask

    initial begin
        int cyc;
        int wd_n;
        logic [4:0] wd_last_pc;

        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        wd_start       = 1'b0;
        zero_flag      = 1'b0;
        op_if.op_ready = 1'b1;
        load_shipped();

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_valid", op_if.op_valid, 1'b0);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_fields", {op_if.op_code, op_if.op_a, op_if.op_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", busy, 1'b0);

        // Shipped program, datapath always ready
        pulse_start();
        run_to_halt(200);
        check_shipped();

        // Backpressure on the first op
        op_if.op_ready = 1'b0;
        pulse_start();
        cyc = 0;
        while (!op_if.op_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("bp_wait_valid", op_if.op_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", op_if.op_valid, 1'b1);
            check_eq("bp_fields", {op_if.op_code, op_if.op_a, op_if.op_b},
                     {3'd2, 3'd4, 2'd0});
            check_eq("bp_pc", pc, 0);
            @(negedge clk);
        end
        op_if.op_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_accept_pc", pc, 1);
        check_eq("bp_accept_valid", op_if.op_valid, 1'b0);
        run_to_halt(200);
        check_eq("bp_rest_n_iss", n_iss, 3);
        check_eq("bp_rest_pc", pc, 10);

        // Async reset while an op is pending
        pulse_start();
        cyc = 0;
        while (pc != 5'd1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ar_wait_pc1", pc, 1);
        op_if.op_ready = 1'b0;
        cyc = 0;
        while (!op_if.op_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ar_wait_valid", op_if.op_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_valid", op_if.op_valid, 1'b0);
        check_eq("ar_pc", pc, 0);
        check_eq("ar_busy", busy, 1'b0);
        check_eq("ar_halted", halted, 1'b0);
        @(negedge clk);
        rst_n          = 1'b1;
        op_if.op_ready = 1'b1;
        pulse_start();
        run_to_halt(200);
        check_shipped();

        // JZ taken and not taken
        fill_rom(8'hE0);
        rom_mem[0] = 8'b110_00011;
        zero_flag  = 1'b1;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check_eq("jz1_rom_addr", rom_addr, 3);
        check_eq("jz1_valid", op_if.op_valid, 1'b0);
        run_to_halt(50);
        check_eq("jz1_n_iss", n_iss, 0);
        check_eq("jz1_err", err, 1'b0);
        check_eq("jz1_pc", pc, 3);
        zero_flag = 1'b0;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check_eq("jz0_rom_addr", rom_addr, 1);
        check_eq("jz0_valid", op_if.op_valid, 1'b0);
        run_to_halt(50);
        check_eq("jz0_n_iss", n_iss, 0);
        check_eq("jz0_pc", pc, 1);

        // Watchdog with STEP_LIMIT=4 on an all-zero ROM
        @(negedge clk);
        wd_start = 1'b1;
        @(negedge clk);
        wd_start   = 1'b0;
        wd_n       = 0;
        wd_last_pc = '0;
        cyc        = 0;
        while (!wd_halted && cyc < 100) begin
            if (wd_if.op_valid) begin
                wd_last_pc = wd_pc;
                wd_n++;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("wd_halted", wd_halted, 1'b1);
        check_eq("wd_n_iss", wd_n, 4);
        check_eq("wd_last_pc", wd_last_pc, 3);
        check_eq("wd_err", wd_err, 1'b1);
        check_eq("wd_pc", wd_pc, 4);

        // PC wrap with the full 255-step limit
        fill_rom(8'h00);
        pulse_start();
        run_to_halt(2000);
        check_eq("wrap_n_iss", n_iss, 255);
        check_eq("wrap_pc31", iss_pc[31], 31);
        check_eq("wrap_pc32", iss_pc[32], 0);
        check_eq("wrap_pc254", iss_pc[254], 30);
        check_eq("wrap_err", err, 1'b1);
        check_eq("wrap_pc_end", pc, 31);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_program_sequencer.md
Name: rom_program_sequencer

Overview:
Instruction fetch/decode sequencer that reads 8-bit instruction words from the combinational program ROM (5-bit address) and walks the program.
- Jump-class opcodes (JMP, JZ, HALT) are resolved internally.
- Every other opcode is issued to the datapath as decoded fields over a valid/ready handshake.
- Sits between the program ROM and the datapath/register-file control of the lab processor.

Parameters:
ADDR_W, 5, ROM address / PC width; equals the jump-target field width (DATA_W-3)
DATA_W, 8, instruction width; format is opcode[7:5] plus either a[4:2],b[1:0] or target[4:0]
STEP_LIMIT, 255, maximum executed instructions per run before watchdog halt (8-bit step counter)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run from address 0; sampled only in IDLE or HALT
rom_addr  out  ADDR_W  address to ROM; always equals pc
rom_data  in  DATA_W  instruction word from ROM (combinational, valid same cycle)
zero_flag  in  1  datapath zero flag, sampled in DECODE for JZ
op_valid  out  1  decoded operation available
op_ready  in  1  datapath accepts operation
op_code  out  3  opcode of issued operation
op_a  out  3  field a (instr[4:2])
op_b  out  2  field b (instr[1:0])
pc  out  ADDR_W  current program counter
busy  out  1  high in FETCH/DECODE/ISSUE
halted  out  1  high in HALT
err  out  1  watchdog halt indicator, valid while halted

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc, ir, step_cnt, op_code, op_a, op_b = 0.
  - op_valid, halted, err, busy = 0.
- Opcode map:
  - 101 JMP: pc<=target.
  - 110 JZ: pc<=target if zero_flag, else pc+1.
  - 111 HALT.
  - 000,001,010,011,100: execute-class, issued to the datapath.
- PC increment wraps modulo 2^ADDR_W (31 -> 0).
- IDLE:
  - rom_addr=0.
  - start=1 -> pc<=0, step_cnt<=0, err<=0 -> FETCH.
- FETCH (1 cycle): ir<=rom_data -> DECODE.
- DECODE (1 cycle):
  - If step_cnt==STEP_LIMIT: err<=1 -> HALT; instruction not executed; pc unchanged.
  - Otherwise step_cnt<=step_cnt+1, then by opcode:
    - JMP with target==pc (self-jump = program end): -> HALT, err=0, pc unchanged.
    - JMP otherwise: pc<=target -> FETCH.
    - JZ: branch per zero_flag sampled this cycle -> FETCH. A JZ to its own address with zero_flag=1 is NOT a halt; it loops and is caught by the watchdog.
    - HALT: -> HALT.
    - Execute-class: op_code/op_a/op_b<=ir fields, op_valid<=1 -> ISSUE.
- ISSUE:
  - op_valid and fields held stable until op_valid&op_ready at a clock edge.
  - On that edge: op_valid<=0, pc<=pc+1 -> FETCH.
  - op_ready is ignored in all other states.
- HALT:
  - halted=1; pc, err and the op_* field values hold.
  - start=1 -> restart as from IDLE: pc=0, err=0, step_cnt=0, next state FETCH.
- start is ignored in FETCH, DECODE and ISSUE.
- Latency:
  - Execute instruction: 3 cycles minimum (FETCH, DECODE, ISSUE with op_ready already high).
  - JMP/JZ: 2 cycles.
  - op_valid rises one cycle after DECODE.
- Reset mid-operation: immediate return to reset values. op_valid drops asynchronously, and no handshake completes in that cycle.

Test Plan:
- Program ROM as shipped, op_ready=1, pulse start:
  - Issues exactly four ops, in order (code,a,b) = (2,4,0)@0, (0,7,2)@1, (0,6,0)@8, (1,5,0)@9. Addresses 2 and 10 are jumps, so nothing is issued there.
  - Then halted=1, err=0, pc=10.
  - 6 decodes total.
- Backpressure: hold op_ready=0 for 5 cycles on the first op -> op_valid=1 and code/a/b=(2,4,0) stable all 5 cycles. pc=0 until ready; pc=1 on the accepting edge.
- JZ: ROM[0]=110_00011.
  - zero_flag=1 -> next rom_addr=3.
  - Repeat with zero_flag=0 -> next rom_addr=1. No op_valid in either case.
- Watchdog: STEP_LIMIT=4, ROM all 0x00 -> four issues (addr 0..3), then halted=1, err=1, pc=4.
- Wrap: STEP_LIMIT=255, ROM all 0x00 -> after the issue at addr 31 the next rom_addr=0. Halts with err=1 after 255 issues, pc=31 (255 mod 32).
- Async reset: assert rst_n=0 mid-ISSUE (op_valid=1) -> op_valid=0, pc=0, busy=0 without a clock edge. start afterwards reruns the first scenario identically.
